// File: rtl/operand_loader.sv
// operand_loader
//
// Upstream feeder for the calculation array. Streamed 16-bit words arrive
// over a valid/ready handshake. The first 8 accepted words of a frame fill
// the A load buffer and the next 8 fill the B load buffer; word 0 of each
// half lands in the least significant slot. A completed pair is copied into
// a held output register qualified by out_valid/out_ready. Because the load
// buffers and the output register are separate, a new frame can fill while
// the previous one waits downstream, which sustains one frame per 16 cycles.
//
// Ports:
//   clk         single clock, all state on the rising edge
//   rst         synchronous, active-high reset
//   in_valid    in_data holds a word
//   in_ready    block accepts a word this cycle
//   in_data     streamed word
//   clear       synchronous discard of the frame being loaded
//   out_valid   out_a/out_b hold a complete frame
//   out_ready   downstream consumes the frame this cycle
//   out_a       A operand vector (slot 0 in bits [WORD_W-1:0])
//   out_b       B operand vector (slot 0 in bits [WORD_W-1:0])
//   frame_count frames moved into the output register, wraps at 0xFFFF

module operand_loader #(
    parameter int WORD_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*WORDS-1:0]  out_a,
    output logic [WORD_W*WORDS-1:0]  out_b,
    output logic [15:0]              frame_count
);

    localparam int VEC_W  = WORD_W * WORDS;
    localparam int IDX_W  = $clog2(2 * WORDS);
    localparam int SLOT_W = IDX_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WORDS - 1);

    // The fill state is fully described by the word index and the complete
    // flag; the enum is a decoded view used by the next-state logic.
    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        FULL
    } state_t;

    logic [IDX_W-1:0]  r_idx;
    logic              r_complete;
    logic [VEC_W-1:0]  r_loadA;
    logic [VEC_W-1:0]  r_loadB;
    logic [VEC_W-1:0]  r_outA;
    logic [VEC_W-1:0]  r_outB;
    logic              r_outValid;
    logic [15:0]       r_frameCount;

    state_t            w_state;
    logic              w_slotFree;
    logic              w_inReady;
    logic              w_accept;
    logic              w_transfer;
    logic [SLOT_W-1:0] w_slot;
    logic [IDX_W-1:0]  w_idxNext;
    logic              w_completeNext;
    logic              w_outValidNext;
    logic [15:0]       w_frameCountNext;

    // Handshake qualifiers and next-state decode. clear takes priority over
    // both accepting and transferring, so a frame completed in the same cycle
    // as clear never reaches the output register.
    always_comb begin
        w_state          = FILL_A;
        w_slotFree       = 1'b0;
        w_inReady        = 1'b0;
        w_accept         = 1'b0;
        w_transfer       = 1'b0;
        w_slot           = r_idx[SLOT_W-1:0];
        w_idxNext        = r_idx;
        w_completeNext   = r_complete;
        w_outValidNext   = r_outValid;
        w_frameCountNext = r_frameCount;

        if (r_complete) begin
            w_state = FULL;
        end else if (r_idx[IDX_W-1]) begin
            w_state = FILL_B;
        end

        w_slotFree = !r_outValid || out_ready;
        w_inReady  = !rst && !clear && ((w_state != FULL) || w_slotFree);
        w_accept   = in_valid && w_inReady;
        w_transfer = (w_state == FULL) && w_slotFree && !clear;

        if (clear) begin
            w_idxNext      = '0;
            w_completeNext = 1'b0;
        end else begin
            case (w_state)
                FILL_A, FILL_B: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            w_idxNext      = '0;
                            w_completeNext = 1'b1;
                        end else begin
                            w_idxNext = r_idx + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    // A word taken in the transfer cycle is already slot 0
                    // of the next frame, so the index moves on to 1.
                    if (w_transfer) begin
                        w_completeNext = 1'b0;
                        w_idxNext      = w_accept ? IDX_W'(1) : '0;
                    end
                end
                default: begin
                    w_idxNext      = '0;
                    w_completeNext = 1'b0;
                end
            endcase
        end

        if (w_transfer) begin
            w_outValidNext   = 1'b1;
            w_frameCountNext = r_frameCount + 16'd1;
        end else if (r_outValid && out_ready) begin
            w_outValidNext = 1'b0;
        end
    end

    // State, load buffers and the held output register. The load buffer is
    // written at the current index; in FULL the index is 0, which is where a
    // word accepted during a transfer belongs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_complete   <= 1'b0;
            r_loadA      <= '0;
            r_loadB      <= '0;
            r_outA       <= '0;
            r_outB       <= '0;
            r_outValid   <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_idx        <= w_idxNext;
            r_complete   <= w_completeNext;
            r_outValid   <= w_outValidNext;
            r_frameCount <= w_frameCountNext;

            if (w_accept) begin
                if (!r_idx[IDX_W-1]) begin
                    r_loadA[int'(w_slot) * WORD_W +: WORD_W] <= in_data;
                end else begin
                    r_loadB[int'(w_slot) * WORD_W +: WORD_W] <= in_data;
                end
            end

            if (w_transfer) begin
                r_outA <= r_loadA;
                r_outB <= r_loadB;
            end
        end
    end

    assign in_ready    = w_inReady;
    assign out_valid   = r_outValid;
    assign out_a       = r_outA;
    assign out_b       = r_outB;
    assign frame_count = r_frameCount;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader
//
// Directed bench for operand_loader. Every accepted word is fed into a small
// frame model; a completed frame is pushed onto a scoreboard and popped when
// the DUT hands it downstream (out_valid && out_ready).

module tb_operand_loader;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_a;
    logic [127:0] out_b;
    logic [15:0]  frame_count;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int stallCycles = 0;
    int expFrames = 0;
    int modelIdx = 0;
    logic [15:0]  modelWords [16];
    logic [255:0] sb [$];
    int pulseCycles [$];
    logic prevValid = 1'b0;

    operand_loader #(
        .WORD_W (16),
        .WORDS  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .frame_count (frame_count)
    );

    // Free-running clock and a cycle counter used for pulse spacing.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case the DUT wedges outside a bounded wait.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Vector of eight consecutive words starting at base, slot 0 lowest.
    function automatic logic [127:0] buildVec(input logic [15:0] base);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v[i*16 +: 16] = base + 16'(i);
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Frame model: record one accepted word, push the frame when 16 are in.
    task automatic modelAccept(input logic [15:0] word);
        logic [127:0] a;
        logic [127:0] b;
        modelWords[modelIdx] = word;
        modelIdx++;
        if (modelIdx == 16) begin
            a = '0;
            b = '0;
            for (int i = 0; i < 8; i++) begin
                a[i*16 +: 16] = modelWords[i];
                b[i*16 +: 16] = modelWords[i+8];
            end
            sb.push_back({a, b});
            expFrames++;
            modelIdx = 0;
        end
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [15:0] word);
        int  waited;
        bit  done;
        waited   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = word;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                modelAccept(word);
                done = 1'b1;
            end else begin
                stallCycles++;
                waited++;
                if (waited > 100) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL accept_timeout observed=stalled expected=accepted word=%0h", word);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [15:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(base + 16'(i));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer and out_valid pulse recorder.
    always @(negedge clk) begin
        logic [255:0] exp;
        if (!rst) begin
            if (out_valid && !prevValid) pulseCycles.push_back(cycleCount);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 128'(sb.size()), 128'd1);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("sb_out_a", out_a, exp[255:128]);
                    checkOutput("sb_out_b", out_b, exp[127:0]);
                end
            end
        end
        prevValid = out_valid;
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;

        // Reset values.
        @(negedge clk);
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_out_a", out_a, 128'd0);
        checkOutput("rst_out_b", out_b, 128'd0);
        checkOutput("rst_frame_count", 128'(frame_count), 128'd0);
        checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 128'(in_ready), 128'd1);
        nextCycle();

        // First frame, words 0x0001..0x0010, downstream always ready.
        $display("[TB] single frame");
        out_ready = 1'b1;
        sendFrame(16'h0001, 16);
        @(negedge clk);
        checkOutput("lat_valid_early", 128'(out_valid), 128'd0);
        @(negedge clk);
        checkOutput("lat_valid", 128'(out_valid), 128'd1);
        checkOutput("f1_out_a", out_a, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        checkOutput("f1_out_b", out_b, 128'h0010_000F_000E_000D_000C_000B_000A_0009);
        checkOutput("f1_frame_count", 128'(frame_count), 128'd1);
        @(negedge clk);
        checkOutput("f1_valid_pulse", 128'(out_valid), 128'd0);
        nextCycle();

        // Continuous 48-word stream: no stalls, pulses 16 cycles apart.
        $display("[TB] continuous stream");
        stallCycles = 0;
        pulseCycles.delete();
        sendFrame(16'h0100, 48);
        repeat (3) nextCycle();
        checkOutput("stream_stalls", 128'(stallCycles), 128'd0);
        checkOutput("stream_pulses", 128'(pulseCycles.size()), 128'd3);
        if (pulseCycles.size() == 3) begin
            checkOutput("stream_gap0", 128'(pulseCycles[1] - pulseCycles[0]), 128'd16);
            checkOutput("stream_gap1", 128'(pulseCycles[2] - pulseCycles[1]), 128'd16);
        end
        checkOutput("stream_frame_count", 128'(frame_count), 128'(expFrames));

        // Backpressure: frame held, second frame fills, then in_ready drops.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        stallCycles = 0;
        sendFrame(16'h0A00, 16);
        sendFrame(16'h0B00, 16);
        checkOutput("bp_fill_stalls", 128'(stallCycles), 128'd0);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
            checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
            checkOutput("bp_out_a_held", out_a, buildVec(16'h0A00));
            checkOutput("bp_count_held", 128'(frame_count), 128'(expFrames - 1));
            nextCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_reraise", 128'(in_ready), 128'd1);
        @(negedge clk);
        checkOutput("bp_f2_out_a", out_a, buildVec(16'h0B00));
        checkOutput("bp_f2_out_b", out_b, buildVec(16'h0B08));
        checkOutput("bp_frame_count", 128'(frame_count), 128'(expFrames));
        nextCycle();

        // Partial frame discarded by clear.
        $display("[TB] clear partial frame");
        sendFrame(16'h00C0, 5);
        clear = 1'b1;
        @(negedge clk);
        checkOutput("clr_in_ready", 128'(in_ready), 128'd0);
        nextCycle();
        clear    = 1'b0;
        modelIdx = 0;
        sendFrame(16'h0100, 16);
        @(negedge clk);
        @(negedge clk);
        checkOutput("clr_valid", 128'(out_valid), 128'd1);
        checkOutput("clr_a_slot0", 128'(out_a[15:0]), 128'h0100);
        checkOutput("clr_b_slot7", 128'(out_b[127:112]), 128'h010F);
        checkOutput("clr_frame_count", 128'(frame_count), 128'(expFrames));
        repeat (2) nextCycle();

        // clear wins over a transfer that would happen in the same cycle.
        $display("[TB] clear versus transfer");
        out_ready = 1'b0;
        sendFrame(16'h0D00, 16);
        sendFrame(16'h0E00, 16);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("cvt_in_ready", 128'(in_ready), 128'd0);
        nextCycle();
        clear = 1'b0;
        void'(sb.pop_back());
        expFrames--;
        modelIdx = 0;
        @(negedge clk);
        checkOutput("cvt_out_a_kept", out_a, buildVec(16'h0D00));
        checkOutput("cvt_out_b_kept", out_b, buildVec(16'h0D08));
        checkOutput("cvt_frame_count", 128'(frame_count), 128'(expFrames));
        nextCycle();
        sendFrame(16'h0F00, 16);
        @(negedge clk);
        @(negedge clk);
        checkOutput("cvt_next_out_a", out_a, buildVec(16'h0F00));
        checkOutput("cvt_next_count", 128'(frame_count), 128'(expFrames));
        repeat (2) nextCycle();

        // Reset mid-frame while an output frame is held.
        $display("[TB] reset mid-frame");
        out_ready = 1'b0;
        sendFrame(16'h1100, 16);
        sendFrame(16'h1200, 10);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mrst_in_ready", 128'(in_ready), 128'd0);
        nextCycle();
        rst = 1'b0;
        sb.delete();
        expFrames = 0;
        modelIdx  = 0;
        @(negedge clk);
        checkOutput("mrst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("mrst_out_a", out_a, 128'd0);
        checkOutput("mrst_out_b", out_b, 128'd0);
        checkOutput("mrst_frame_count", 128'(frame_count), 128'd0);
        nextCycle();
        out_ready = 1'b1;
        sendFrame(16'h1300, 15);
        repeat (3) @(negedge clk);
        checkOutput("mrst_partial_count", 128'(frame_count), 128'd0);
        checkOutput("mrst_partial_valid", 128'(out_valid), 128'd0);
        nextCycle();
        applyStimulus(16'h130F);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mrst_full_out_a", out_a, buildVec(16'h1300));
        checkOutput("mrst_full_count", 128'(frame_count), 128'd1);
        repeat (3) nextCycle();

        checkOutput("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
